// File: rtl/pwm_config_regfile.sv
`default_nettype none
// ============================================================================
// pwm_config_regfile: SPI-slave shadow register bank with period-aligned
// double-buffered active copies for the PWM timer channels.
// Revision: 1.0
// ============================================================================
module pwm_config_regfile #(
  parameter int CHANNELS = 4
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    SCK,
  input  logic                    MOSI,
  input  logic                    _CS,
  output logic                    MISO,
  input  logic [CHANNELS-1:0]     PeriodEnd,
  output logic [16*CHANNELS-1:0]  Prescaler,
  output logic [16*CHANNELS-1:0]  Count,
  output logic [16*CHANNELS-1:0]  SwitchValue,
  output logic [CHANNELS-1:0]     ChannelEnable
);

  localparam logic [15:0] C_COUNT_RST = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [1:0]  sck_sync_q, mosi_sync_q, cs_sync_q;
  logic        sck_prev_q, cs_prev_q;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [14:0] shift_in_q, shift_in_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] shift_out_q, shift_out_d;

  logic [15:0] presc_sh_q [CHANNELS];
  logic [15:0] cnt_sh_q   [CHANNELS];
  logic [15:0] sw_sh_q    [CHANNELS];
  logic [CHANNELS-1:0] en_sh_q;
  logic [15:0] presc_act_q [CHANNELS];
  logic [15:0] cnt_act_q   [CHANNELS];
  logic [15:0] sw_act_q    [CHANNELS];
  logic [CHANNELS-1:0] en_act_q;

  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_mosi, w_wr_en;
  logic [7:0]  w_cmd_next;
  logic [15:0] w_wr_data, w_rd_data;

  assign w_sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign w_sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign w_cs_fall  = cs_prev_q & ~cs_sync_q[1];
  assign w_mosi     = mosi_sync_q[1];
  assign w_cmd_next = {shift_in_q[6:0], w_mosi};
  assign w_wr_data  = {shift_in_q, w_mosi};

  // Addresses beyond the last channel match no channel and so read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_cmd_next[6:2] == 5'(i)) begin
        case (w_cmd_next[1:0])
          2'd0:    w_rd_data = presc_sh_q[i];
          2'd1:    w_rd_data = cnt_sh_q[i];
          2'd2:    w_rd_data = sw_sh_q[i];
          default: w_rd_data = {15'd0, en_sh_q[i]};
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    cmd_d       = cmd_q;
    shift_out_d = shift_out_q;
    w_wr_en     = 1'b0;
    if (cs_sync_q[1]) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (w_sck_rise) begin
            shift_in_d = {shift_in_q[13:0], w_mosi};
            if (bit_cnt_q == 4'd7) begin
              state_d     = S_DATA;
              bit_cnt_d   = '0;
              cmd_d       = w_cmd_next;
              shift_out_d = w_cmd_next[7] ? 16'h0000 : w_rd_data;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_sck_rise) begin
            shift_in_d = {shift_in_q[13:0], w_mosi};
            if (bit_cnt_q == 4'd15) begin
              state_d   = S_DONE;
              bit_cnt_d = '0;
              w_wr_en   = cmd_q[7];
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (w_sck_fall && bit_cnt_q != 4'd0) begin
            // Hold bit 15 until the host has sampled it on the first data edge.
            shift_out_d = {shift_out_q[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      cmd_q       <= '0;
      shift_out_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], SCK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      cs_sync_q   <= {cs_sync_q[0], _CS};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      cmd_q       <= cmd_d;
      shift_out_q <= shift_out_d;
    end
  end

  // Active copies sample the shadow before any same-cycle shadow write lands.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        presc_sh_q[i]  <= '0;
        cnt_sh_q[i]    <= C_COUNT_RST;
        sw_sh_q[i]     <= '0;
        presc_act_q[i] <= '0;
        cnt_act_q[i]   <= C_COUNT_RST;
        sw_act_q[i]    <= '0;
      end
      en_sh_q  <= '0;
      en_act_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (PeriodEnd[i] || !en_act_q[i]) begin
          presc_act_q[i] <= presc_sh_q[i];
          cnt_act_q[i]   <= cnt_sh_q[i];
          sw_act_q[i]    <= sw_sh_q[i];
          en_act_q[i]    <= en_sh_q[i];
        end
        if (w_wr_en && cmd_q[6:2] == 5'(i)) begin
          case (cmd_q[1:0])
            2'd0:    presc_sh_q[i] <= w_wr_data;
            2'd1:    cnt_sh_q[i]   <= w_wr_data;
            2'd2:    sw_sh_q[i]    <= w_wr_data;
            default: en_sh_q[i]    <= w_wr_data[0];
          endcase
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign Prescaler[16*g +: 16]   = presc_act_q[g];
      assign Count[16*g +: 16]       = cnt_act_q[g];
      assign SwitchValue[16*g +: 16] = sw_act_q[g];
    end
  endgenerate

  assign ChannelEnable = en_act_q;
  assign MISO          = (state_q == S_DATA) ? shift_out_q[15] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pwm_config_regfile.sv
`default_nettype none
// tb_pwm_config_regfile: scoreboard bench driving SPI frames and PeriodEnd
// pulses against a register-map reference model.
module tb_pwm_config_regfile;
  localparam int CH   = 4;
  localparam int HALF = 5;

  logic CLK = 1'b0, _RST = 1'b0, SCK = 1'b0, MOSI = 1'b0, _CS = 1'b1;
  logic [CH-1:0] PeriodEnd = '0;
  logic MISO;
  logic [16*CH-1:0] Prescaler, Count, SwitchValue;
  logic [CH-1:0] ChannelEnable;

  pwm_config_regfile #(.CHANNELS(CH)) dut (
    .CLK(CLK), ._RST(_RST), .SCK(SCK), .MOSI(MOSI), ._CS(_CS), .MISO(MISO),
    .PeriodEnd(PeriodEnd), .Prescaler(Prescaler), .Count(Count),
    .SwitchValue(SwitchValue), .ChannelEnable(ChannelEnable)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [16*CH-1:0] p, c, s;
    logic [CH-1:0]    e;
  } snap_t;
  snap_t       exp_q[$];
  logic [15:0] rd_q[$];

  logic [15:0] m_sh_p[CH], m_sh_c[CH], m_sh_s[CH];
  logic [15:0] m_act_p[CH], m_act_c[CH], m_act_s[CH];
  logic        m_sh_e[CH], m_act_e[CH];

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_sh_p[i] = 16'h0000; m_sh_c[i] = 16'hFFFF; m_sh_s[i] = 16'h0000; m_sh_e[i] = 1'b0;
      m_act_p[i] = 16'h0000; m_act_c[i] = 16'hFFFF; m_act_s[i] = 16'h0000; m_act_e[i] = 1'b0;
    end
  endfunction

  function automatic void m_copy(input int ch);
    m_act_p[ch] = m_sh_p[ch];
    m_act_c[ch] = m_sh_c[ch];
    m_act_s[ch] = m_sh_s[ch];
    m_act_e[ch] = m_sh_e[ch];
  endfunction

  // A disabled channel follows its shadow continuously.
  function automatic void m_track();
    for (int i = 0; i < CH; i++)
      if (!m_act_e[i]) m_copy(i);
  endfunction

  function automatic void m_write(input int addr, input logic [15:0] d);
    if (addr < 4*CH) begin
      case (addr % 4)
        0: m_sh_p[addr/4] = d;
        1: m_sh_c[addr/4] = d;
        2: m_sh_s[addr/4] = d;
        default: m_sh_e[addr/4] = d[0];
      endcase
    end
  endfunction

  function automatic logic [15:0] m_read(input int addr);
    if (addr >= 4*CH) return 16'h0000;
    case (addr % 4)
      0: return m_sh_p[addr/4];
      1: return m_sh_c[addr/4];
      2: return m_sh_s[addr/4];
      default: return {15'd0, m_sh_e[addr/4]};
    endcase
  endfunction

  function automatic void push_expect();
    snap_t s;
    for (int i = 0; i < CH; i++) begin
      s.p[16*i +: 16] = m_act_p[i];
      s.c[16*i +: 16] = m_act_c[i];
      s.s[16*i +: 16] = m_act_s[i];
      s.e[i]          = m_act_e[i];
    end
    exp_q.push_back(s);
  endfunction

  task automatic spi_begin();
    @(negedge CLK); _CS = 1'b0;
    repeat (HALF) @(negedge CLK);
  endtask

  // Returns right after the last requested rising edge, SCK left high.
  task automatic spi_bits(input logic [23:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) begin
        repeat (HALF) @(negedge CLK);
        SCK = 1'b0;
      end
      @(negedge CLK); MOSI = fr[23-i];
      repeat (HALF-1) @(negedge CLK);
      SCK = 1'b1;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge CLK); SCK = 1'b0;
    repeat (HALF) @(negedge CLK); _CS = 1'b1; MOSI = 1'b0;
    repeat (2*HALF) @(negedge CLK);
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [15:0] d);
    if (!cmd[7]) rd_q.push_back(m_read(int'(cmd[6:0])));
    spi_begin();
    spi_bits({cmd, d}, 24);
    spi_end();
    if (cmd[7]) m_write(int'(cmd[6:0]), d);
    m_track();
    @(posedge CLK); push_expect();
  endtask

  task automatic pulse(input int ch);
    @(negedge CLK); PeriodEnd[ch] = 1'b1;
    @(posedge CLK);
    m_copy(ch); m_track(); push_expect();
    @(negedge CLK); PeriodEnd[ch] = 1'b0;
  endtask

  // Output monitor: compares every queued snapshot at the next falling CLK edge.
  initial begin : out_mon
    snap_t s;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("Prescaler", 64'(Prescaler), 64'(s.p));
        chk("Count", 64'(Count), 64'(s.c));
        chk("SwitchValue", 64'(SwitchValue), 64'(s.s));
        chk("ChannelEnable", 64'(ChannelEnable), 64'(s.e));
        chk("miso_idle", 64'(MISO), 64'd0);
      end
    end
  end

  // SPI monitor: samples MISO as a mode-0 host would, on each SCK rising edge.
  initial begin : spi_mon
    int n;
    logic [7:0] cmd;
    logic [15:0] got;
    logic cmd_miso;
    n = 0; cmd = '0; got = '0; cmd_miso = 1'b0;
    forever begin
      @(posedge SCK or posedge _CS);
      if (_CS) begin
        n = 0;
      end else begin
        n++;
        if (n == 1) cmd_miso = 1'b0;
        if (n <= 8) begin
          cmd = {cmd[6:0], MOSI};
          cmd_miso = cmd_miso | MISO;
          if (n == 8) chk("miso_cmd_phase", 64'(cmd_miso), 64'd0);
        end else if (n <= 24) begin
          got = {got[14:0], MISO};
          if (n == 24 && !cmd[7]) begin
            if (rd_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL read_data: got %h with no expected read pending", got);
            end else begin
              chk("read_data", 64'(got), 64'(rd_q.pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a;
    logic [7:0] cmd;
    logic [15:0] d;
    m_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK); _RST = 1'b1;
    @(posedge CLK); push_expect();

    // Disabled channel: Count goes live exactly 4 CLK after the last SCK rise.
    spi_begin();
    spi_bits({8'h81, 16'h1234}, 24);
    m_write(1, 16'h1234); m_track();
    repeat (4) @(posedge CLK); push_expect();
    spi_end();
    spi_xfer(8'h01, 16'h0000);

    // Enabled channel 1 holds SwitchValue until its period boundary.
    spi_xfer(8'h87, 16'h0001);
    spi_xfer(8'h86, 16'h0100);
    pulse(1);

    // Shadow write coincident with PeriodEnd[2].
    spi_xfer(8'h8A, 16'hAAAA);
    spi_xfer(8'h8B, 16'h0001);
    spi_begin();
    spi_bits({8'h8A, 16'h5555}, 24);
    repeat (2) @(posedge CLK);
    @(negedge CLK); PeriodEnd[2] = 1'b1;
    @(posedge CLK);
    m_copy(2); m_write(10, 16'h5555); push_expect();
    @(negedge CLK); PeriodEnd[2] = 1'b0;
    spi_end();
    pulse(2);

    // Aborted frame, then a complete one.
    spi_begin();
    spi_bits({8'h80, 16'h0ABC}, 12);
    spi_end();
    @(posedge CLK); push_expect();
    spi_xfer(8'h80, 16'h0007);

    // Out-of-range address.
    spi_xfer(8'hFF, 16'hBEEF);
    spi_xfer(8'h7F, 16'h0000);
    spi_xfer(8'h0B, 16'h0000);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(16, 127));
      else a = int'($urandom_range(0, 15));
      cmd = {1'($urandom_range(0, 1)), 7'(a)};
      d = 16'($urandom);
      spi_xfer(cmd, d);
      if ($urandom_range(0, 2) == 0) pulse(int'($urandom_range(0, CH-1)));
    end

    // Reset in the middle of a frame, then confirm the bus recovers.
    spi_begin();
    spi_bits({8'h82, 16'h4321}, 10);
    @(negedge CLK); _RST = 1'b0; SCK = 1'b0; _CS = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge CLK); _RST = 1'b1;
    m_reset();
    @(posedge CLK); push_expect();
    repeat (2*HALF) @(negedge CLK);
    spi_xfer(8'h81, 16'h00C3);
    spi_xfer(8'h01, 16'h0000);

    repeat (5) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots and %0d reads left, expected 0", exp_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_config_regfile.md
# pwm_config_regfile

SPI-slave configuration register bank for the PWM IO expander. It receives 24-bit frames from the host microcontroller and holds per-channel Prescaler, Count and SwitchValue words plus an enable bit in shadow registers. It presents double-buffered active copies directly to the downstream PWM timer channels. Shadow-to-active transfer happens only at each channel's period boundary, so timers never see a torn configuration.

## Interface
- CHANNELS, 4, number of PWM timer channels served (1..32)
- CLK  input  1  system clock; all logic synchronous to it
- _RST  input  1  reset, asynchronous, active-low
- SCK  input  1  SPI clock, mode 0, asynchronous to CLK, frequency ≤ CLK/8
- MOSI  input  1  SPI data in, sampled on SCK rising edge
- _CS  input  1  SPI chip select, active-low
- MISO  output  1  SPI data out, changes after SCK falling edge; driven 0 when _CS high
- PeriodEnd  input  CHANNELS  one-CLK pulse per channel from its timer when its counter wraps
- Prescaler  output  16*CHANNELS  active prescaler, channel n at bits [16n+15:16n]
- Count  output  16*CHANNELS  active period terminal count, same packing
- SwitchValue  output  16*CHANNELS  active duty switch point, same packing
- ChannelEnable  output  CHANNELS  active enable bit per channel

## Operation
- SCK, MOSI and _CS each pass through a 2-flop synchronizer. Edges are detected on the synchronized SCK.
- Frame format, MSB first: command byte {RW, ADDR[6:0]} (RW=1 write, 0 read), then 16 data bits.
- Address map: ADDR = 4*ch + reg. reg 0 = Prescaler, 1 = Count, 2 = SwitchValue, 3 = Control (bit0 = enable, other bits read 0). ADDR ≥ 4*CHANNELS is invalid.
- FSM states and transitions:
  - IDLE → CMD on synchronized _CS falling.
  - CMD → DATA after the 8th rising SCK edge. The command is latched at this point; for a read, the shift-out register is loaded with the shadow value, or 0 if invalid.
  - DATA → DONE after the 16th data rising edge. For a valid write, the shadow register is updated on this transition.
  - DONE ignores further SCK edges. Any state → IDLE when _CS goes high.
- _CS deasserted before the 24th edge aborts the frame: no register changes, bit counter cleared.
- Writes to invalid addresses are ignored. Reads from invalid addresses return 16'h0000.
- Reads return the shadow value, not the active value.
- MISO behaviour:
  - 0 during CMD.
  - Presents data bit 15 as soon as DATA is entered, then advances one bit per synchronized SCK falling edge.
  - 0 in DONE and IDLE.
- Shadow → active copy of all four registers of channel n:
  - on the CLK after PeriodEnd[n]=1, or
  - on every CLK while active ChannelEnable[n]=0, so a disabled channel tracks its shadow immediately.
- Reset values, shadow and active:
  - Prescaler 16'h0000, Count 16'hFFFF, SwitchValue 16'h0000, enable 0.
  - MISO 0, FSM IDLE, bit counter 0.

## Timing
- Shadow write completes 3 CLK after the raw 24th SCK rising edge: 2 CLK of synchronization plus 1 CLK register write.
- Active outputs change exactly 1 CLK after the PeriodEnd[n] pulse.
- Simultaneous shadow write and PeriodEnd[n] in the same CLK: active takes the pre-write shadow. The new value applies at the next PeriodEnd[n].
- Enable written 1 while disabled: active enable and all other words go live 1 CLK after the shadow write.
- Enable written 0 while enabled: takes effect at the next PeriodEnd[n]. After that, the channel tracks its shadow.
- _RST asserted mid-frame clears everything immediately. The frame in progress is lost, and the bus resynchronizes on the next _CS falling edge.
- MISO data bit k is valid from ≤ 3 CLK after the corresponding SCK falling edge. This is before the next rising edge given SCK ≤ CLK/8.

## Test plan
- Reset with no SPI activity → all Count words 16'hFFFF; Prescaler, SwitchValue, ChannelEnable and MISO all 0.
- Write 0x81, 0x1234 with ch0 disabled → Count[15:0] = 16'h1234 within 4 CLK of the last SCK edge. Read 0x01 → MISO shifts 0x1234.
- Enable ch1 (write 0x87, 0x0001), then write SwitchValue 0x86, 0x0100 → active unchanged until a PeriodEnd[1] pulse, then 16'h0100 one CLK later.
- Shadow write and PeriodEnd[2] in the same CLK on an enabled channel → old value goes active. The new value goes active only after the second PeriodEnd[2].
- _CS raised after 12 bits of a write to 0x80 → Prescaler[15:0] stays 0. A following full write to 0x80 of 0x0007 succeeds.
- Write to ADDR 0x7F → no output changes. Read of 0x7F → MISO 16'h0000. _RST pulse mid-frame → all outputs return to reset values.
